div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/div_unit.sv | 112 +++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU package: divider state encoding, sizes and sign helpers.
package cpu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_t;

    function automatic logic [DIV_WIDTH-1:0] negate(
        input logic [DIV_WIDTH-1:0] x
    );
        return ~x + DIV_WIDTH'(1);
    endfunction

    // 0x80000000 maps to itself, which is its correct unsigned magnitude
    function automatic logic [DIV_WIDTH-1:0] abs_val(
        input logic [DIV_WIDTH-1:0] x,
        input logic                 sgn
    );
        return (sgn && x[DIV_WIDTH-1]) ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITER  = DIV_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(ITER);

    div_state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dbz_q;

    logic             last;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign last = (cnt_q == CW'(ITER - 1));

    // quo_q shifts dividend bits out of the top while quotient bits enter below
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_next  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        r_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_fix   = dbz_q ? '1 : (neg_q_q ? negate(q_next) : q_next);
        r_fix   = neg_r_q ? negate(r_next) : r_next;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last)  state_d = FIN;
            FIN:             state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            dbz_q       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= abs_val(dividend, is_signed);
                        dvs_q   <= abs_val(divisor, is_signed);
                        neg_q_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_q <= is_signed & dividend[WIDTH-1];
                        dbz_q   <= (divisor == '0);
                    end
                end
                RUN: begin
                    rem_q <= r_next;
                    quo_q <= q_next;
                    cnt_q <= cnt_q + CW'(1);
                    // results land as FIN begins so they are valid with done
                    if (last) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= dbz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, handshake, signs, corner cases, reset.
module tb_div_unit;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Start one op at edge 0, then watch cycles 1..40 (sampled at negedge).
    task automatic run_op(
        input  logic        s,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  int          p1,
        input  int          p2,
        output int          ndone,
        output int          dcyc,
        output logic        bok,
        output logic [31:0] q,
        output logic [31:0] r,
        output logic        z
    );
        ndone = 0;
        dcyc  = -1;
        bok   = 1'b1;
        q     = '0;
        r     = '0;
        z     = 1'b0;
        @(negedge clk);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start    = (cyc == p1) || (cyc == p2);
            dividend = start ? 32'd999 : a;
            if (busy !== (cyc <= LAT)) bok = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                dcyc = cyc;
                q    = quotient;
                r    = remainder;
                z    = div_by_zero;
            end
        end
        start    = 1'b0;
        dividend = a;
    endtask

    int          nd;
    int          dc;
    logic        bok;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quo", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op(1'b0, 32'd100, 32'd7, -1, -1, nd, dc, bok, q, r, z);
        chk("u100_7_q", q, 32'd14);
        chk("u100_7_r", r, 32'd2);
        chk("u100_7_dbz", 32'(z), 32'd0);
        chk("u100_7_ndone", 32'(nd), 32'd1);
        chk("u100_7_dcyc", 32'(dc), 32'd33);
        chk("u100_7_busy", 32'(bok), 32'd1);
        chk("u100_7_held_q", quotient, 32'd14);
        chk("u100_7_held_r", remainder, 32'd2);

        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1, nd, dc, bok, q, r, z);
        chk("s-7_2_q", q, 32'hFFFF_FFFD);
        chk("s-7_2_r", r, 32'hFFFF_FFFF);

        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, -1, -1, nd, dc, bok, q, r, z);
        chk("s7_-2_q", q, 32'hFFFF_FFFD);
        chk("s7_-2_r", r, 32'd1);

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nd, dc, bok, q, r, z);
        chk("smin_-1_q", q, 32'h8000_0000);
        chk("smin_-1_r", r, 32'd0);
        chk("smin_-1_dbz", 32'(z), 32'd0);

        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, -1, -1, nd, dc, bok, q, r, z);
        chk("umax_1_q", q, 32'hFFFF_FFFF);
        chk("umax_1_r", r, 32'd0);

        run_op(1'b0, 32'h1234, 32'd0, -1, -1, nd, dc, bok, q, r, z);
        chk("u_dz_q", q, 32'hFFFF_FFFF);
        chk("u_dz_r", r, 32'h1234);
        chk("u_dz_dbz", 32'(z), 32'd1);
        chk("u_dz_dcyc", 32'(dc), 32'd33);

        run_op(1'b0, 32'd9, 32'd3, -1, -1, nd, dc, bok, q, r, z);
        chk("u9_3_q", q, 32'd3);
        chk("u9_3_r", r, 32'd0);
        chk("u9_3_dbz", 32'(z), 32'd0);

        run_op(1'b1, 32'hFFFF_FFF8, 32'd0, -1, -1, nd, dc, bok, q, r, z);
        chk("s_dz_q", q, 32'hFFFF_FFFF);
        chk("s_dz_r", r, 32'hFFFF_FFF8);
        chk("s_dz_dbz", 32'(z), 32'd1);

        run_op(1'b0, 32'd100, 32'd7, 5, 33, nd, dc, bok, q, r, z);
        chk("ign_ndone", 32'(nd), 32'd1);
        chk("ign_dcyc", 32'(dc), 32'd33);
        chk("ign_busy", 32'(bok), 32'd1);
        chk("ign_q", q, 32'd14);
        chk("ign_r", r, 32'd2);

        // reset mid-operation in cycle 10
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quo", quotient, 32'd0);
        nd = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 3) rst_n = 1'b1;
            if (done === 1'b1) nd++;
        end
        chk("abort_nodone", 32'(nd), 32'd0);

        run_op(1'b0, 32'd50, 32'd5, -1, -1, nd, dc, bok, q, r, z);
        chk("u50_5_q", q, 32'd10);
        chk("u50_5_r", r, 32'd0);
        chk("u50_5_dcyc", 32'(dc), 32'd33);
        chk("u50_5_ndone", 32'(nd), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
